// File: rtl/sum8_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sum8_sequencer
// Description : Plays a software-loaded vector table into the sum8
//               accumulator input, one vector per cycle. After the table is
//               played it waits out the accumulator latency, captures the
//               accumulated sum and pulses done. Runs can be restarted or
//               aborted.
//               Optional self-check: define SUM8_SEQ_CHECK_EN to add a shadow
//               accumulator and the sticky mismatch output.
// Revision    : 1.0 - initial release
// ============================================================================
module sum8_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int ACC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [WIDTH-1:0]           cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic                       start,
  input  logic                       abort,
  output logic [WIDTH-1:0]           sum_i,
  input  logic [WIDTH-1:0]           sum_o,
  output logic                       busy,
  output logic                       done,
`ifdef SUM8_SEQ_CHECK_EN
  output logic                       mismatch,
`endif
  output logic [WIDTH-1:0]           result
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = 2;  // ACC_LAT is at most 4, so 0..3 fits
  localparam logic [LW-1:0] LEN_MAX    = LW'(DEPTH);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ACC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w_addr_ok;
  logic             w_mem_we;
  logic             w_start_ok;
  logic             w_drain_end;
  logic [LW-1:0]    w_len_clamped;

  // Only a non-power-of-two depth can see an out-of-range address
  generate
    if ((1 << AW) == DEPTH) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_range
      assign w_addr_ok = (32'(cfg_addr) < DEPTH);
    end
  endgenerate

  assign w_mem_we      = cfg_we && (state_q == IDLE) && w_addr_ok;
  assign w_start_ok    = (state_q == IDLE) && start && !abort;
  assign w_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign w_drain_end   = (state_q == DRAIN) && !abort && (cnt_q == DRAIN_LAST);

  // Vector memory: writable only while idle so a run sees a stable table
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (w_mem_we) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic and vector output; sum_i is zero outside RUN so the
  // accumulator holds its value
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sum_i    = '0;
    unique case (state_q)
      IDLE: begin
        if (w_start_ok) begin
          len_d   = w_len_clamped;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (w_len_clamped == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        sum_i = mem_q[idx_q[AW-1:0]];
        if (abort) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + LW'(1);
          if ((idx_q + LW'(1)) == len_q) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == DRAIN_LAST) begin
          result_d = sum_o;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

`ifdef SUM8_SEQ_CHECK_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  (* mark_debug = "true" *) logic mismatch_q;
  logic             mismatch_d;

  // Shadow sum: base captured at start, then every played vector added
  always_comb begin
    shadow_d   = shadow_q;
    mismatch_d = mismatch_q;
    if (w_start_ok) begin
      shadow_d = sum_o;
    end else if ((state_q == RUN) && !abort) begin
      shadow_d = shadow_q + sum_i;
    end
    if (w_drain_end && (sum_o != shadow_q)) begin
      mismatch_d = 1'b1;
    end
  end

  // Checker registers; mismatch is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum8_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum8_sequencer
// Description : Self-checking bench for sum8_sequencer with a one-cycle
//               accumulator standing in for sum8 and a vector-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum8_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int ACC_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [7:0]       cfg_data = '0;
  logic [3:0]       cfg_len = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       sum_i;
  logic [7:0]       sum_o;
  logic             busy;
  logic             done;
  logic [7:0]       result;
`ifdef SUM8_SEQ_CHECK_EN
  logic             mismatch;
`endif

  // Accumulator environment (one-cycle latency, matches ACC_LAT)
  logic [7:0] acc = '0;
  logic       acc_ld = 1'b0;
  logic [7:0] acc_ld_val = '0;
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = '0;

  // Reference state
  logic [7:0] mem_m [DEPTH];
  logic [7:0] res_m;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acc_ld) acc <= acc_ld_val;
    else        acc <= acc + sum_i;
  end

  assign sum_o = ovr_en ? ovr_val : acc;

  sum8_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ACC_LAT (ACC_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_len  (cfg_len),
    .start    (start),
    .abort    (abort),
    .sum_i    (sum_i),
    .sum_o    (sum_o),
    .busy     (busy),
    .done     (done),
`ifdef SUM8_SEQ_CHECK_EN
    .mismatch (mismatch),
`endif
    .result   (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic set_acc(input logic [7:0] v);
    acc_ld = 1'b1; acc_ld_val = v;
    @(negedge clk);
    acc_ld = 1'b0;
  endtask

  // One run from the idle state; expectations come from the table model:
  // vector k appears in cycle k+1, done in cycle len+ACC_LAT+1,
  // result = base + sum of the played vectors (mod 256).
  task automatic run_check(input int len_cfg, input int abort_cyc, input bit noise);
    int         len;
    logic [7:0] base;
    logic [7:0] exp_sum;
    logic [7:0] part;
    len  = (len_cfg > DEPTH) ? DEPTH : len_cfg;
    base = sum_o;
    exp_sum = base;
    for (int k = 0; k < len; k++) exp_sum = exp_sum + mem_m[k];
    cfg_len = 4'(len_cfg);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= len + ACC_LAT + 1; cyc++) begin
      check_eq("run_busy", busy, 1);
      check_eq("run_sum_i", sum_i, (cyc <= len) ? mem_m[cyc-1] : 8'd0);
      check_eq("run_done", done, (cyc == len + ACC_LAT + 1));
      if (cyc == len + ACC_LAT + 1) begin
        check_eq("run_result", result, exp_sum);
        res_m = exp_sum;
      end
`ifdef SUM8_SEQ_CHECK_EN
      check_eq("run_mismatch", mismatch, 0);
`endif
      start  = 1'b0;
      cfg_we = 1'b0;
      if (cyc == abort_cyc) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        part = base;
        for (int k = 0; k < ((abort_cyc < len) ? abort_cyc : len); k++) part = part + mem_m[k];
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_result", result, res_m);
        check_eq("abort_acc", sum_o, part);
        check_eq("abort_sum_i", sum_i, 0);
        return;
      end
      if (noise && cyc == 1) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 3'($urandom);
        cfg_data = 8'($urandom);
      end
      @(negedge clk);
    end
    check_eq("post_busy", busy, 0);
    check_eq("post_done", done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] base;
    logic [7:0] s3;
    int         lc;
    int         ln;
    int         ab;
    int         nw;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sum_i", sum_i, 0);
    check_eq("rst_result", result, 0);
`ifdef SUM8_SEQ_CHECK_EN
    check_eq("rst_mismatch", mismatch, 0);
`endif
    rst = 1'b1;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    res_m = '0;
    @(negedge clk);

    // Nominal run: 3,5,7,2,4,6 from zero gives 27
    write_mem(0, 3); write_mem(1, 5); write_mem(2, 7);
    write_mem(3, 2); write_mem(4, 4); write_mem(5, 6);
    set_acc(0);
    run_check(6, 0, 0);
    check_eq("nominal_27", result, 27);

    // Zero length with accumulator at 27
    run_check(0, 0, 0);
    check_eq("zero_len_27", result, 27);

    // Mid-run start/cfg_we must be ignored
    run_check(6, 0, 1);

    // Abort in RUN cycle 3 leaves 15 in the accumulator
    set_acc(0);
    run_check(6, 3, 0);
    check_eq("abort_acc_15", sum_o, 15);

    // Wrap-around: 200+100 = 44 mod 256
    write_mem(0, 200); write_mem(1, 100);
    set_acc(0);
    run_check(2, 0, 0);
    check_eq("wrap_44", result, 44);

    // start together with abort in IDLE starts nothing
    start = 1'b1; abort = 1'b1; cfg_len = 4'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    @(negedge clk);
    check_eq("start_abort_busy2", busy, 0);

    // Back-to-back: start held high, runs spaced len+ACC_LAT+2 apart
    base = sum_o;
    s3 = mem_m[0] + mem_m[1] + mem_m[2];
    cfg_len = 4'd3;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_eq("b2b_done", done, (c == 5 || c == 11));
      check_eq("b2b_busy", busy, !(c == 6 || c == 12));
      if (c == 11) begin
        check_eq("b2b_result", result, 8'(base + s3 + s3));
        res_m = 8'(base + s3 + s3);
        start = 1'b0;
      end
    end

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_mem(3'($urandom_range(0, 7)), 8'($urandom));
      lc = $urandom_range(0, 12);
      ln = (lc > DEPTH) ? DEPTH : lc;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ln + ACC_LAT) : 0;
      run_check(lc, ab, 1'($urandom_range(0, 1)));
    end

    // Forced zero on sum_o: result captures it, checker flags it
    write_mem(0, 3); write_mem(1, 5); write_mem(2, 7);
    write_mem(3, 2); write_mem(4, 4); write_mem(5, 6);
    set_acc(0);
    ovr_en = 1'b1; ovr_val = 8'h00;
    cfg_len = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check_eq("forced_done", done, 1);
    check_eq("forced_result", result, 0);
`ifdef SUM8_SEQ_CHECK_EN
    check_eq("forced_mismatch", mismatch, 1);
`endif
    ovr_en = 1'b0;
    repeat (3) @(negedge clk);
`ifdef SUM8_SEQ_CHECK_EN
    check_eq("mismatch_sticky", mismatch, 1);
`endif
    check_eq("forced_result_hold", result, 0);

    // Asynchronous reset in DRAIN
    cfg_len = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_sum_i", sum_i, 0);
    check_eq("arst_result", result, 0);
`ifdef SUM8_SEQ_CHECK_EN
    check_eq("arst_mismatch", mismatch, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    res_m = '0;
    @(negedge clk);
    // Memory must read back zero after reset
    run_check(5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum8_sequencer.md
# sum8_sequencer

Controller that sequences the `sum8` accumulator datapath. It holds a small software-loaded vector memory and, on `start`, plays a programmed number of 8-bit vectors into the `sum8` input, one per cycle. It then waits out the datapath latency, captures the accumulated output and signals completion. It replaces free-running hard-coded stimulus with a restartable, handshaken run, for use both in the on-chip ILA harness and in simulation benches.

## Interface
- `WIDTH`, 8: datapath width; must match `sum8`.
- `DEPTH`, 8: number of vector slots.
- `ACC_LAT`, 1: cycles from a `sum8` input change to the matching output; range 1..4.
- `clk  in  1`: sole clock, rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `cfg_we  in  1`: vector memory write strobe.
- `cfg_addr  in  $clog2(DEPTH)`: write slot index.
- `cfg_data  in  WIDTH`: write data.
- `cfg_len  in  $clog2(DEPTH+1)`: vector count; latched on an accepted `start`.
- `start  in  1`: run request, level-sampled.
- `abort  in  1`: cancel the current run.
- `sum_i  out  WIDTH`: drives the `sum8` input `i`.
- `sum_o  in  WIDTH`: from the `sum8` output `o`.
- `busy  out  1`: high whenever state is not IDLE.
- `done  out  1`: one-cycle completion pulse.
- `result  out  WIDTH`: `sum_o` captured at completion; held until the next completion.
- `mismatch  out  1`: checker flag; exists only with `SUM8_SEQ_CHECK_EN` (see Configuration).

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **Reset** (`rst` = 0) forces:
  - state IDLE;
  - `sum_i`, `busy`, `done`, `result`, `mismatch` all 0;
  - vector memory zeroed;
  - `idx` and `len` set to 0.
- **Memory writes:** when `cfg_we` = 1 in IDLE, `mem[cfg_addr]` <= `cfg_data`.
  - Writes in any other state are dropped.
  - A `cfg_addr` ≥ DEPTH is dropped.
- **IDLE:**
  - `sum_i` = 0, so the accumulator holds its value.
  - When `start` = 1 and `abort` = 0, latch `len` = min(`cfg_len`, DEPTH) and set `idx` = 0.
    - If `len` = 0: go to DRAIN.
    - Otherwise: go to RUN.
- **RUN:**
  - `sum_i` = `mem[idx]`, combinationally from registered `idx`.
  - `idx` increments every cycle.
  - After `len` cycles, go to DRAIN.
- **DRAIN:**
  - `sum_i` = 0 for ACC_LAT cycles.
  - On the final DRAIN edge, `result` <= `sum_o` and the state goes to DONE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Start handling:**
  - `start` is ignored outside IDLE; there is no queuing.
  - `start` held high in IDLE immediately after DONE launches a new run.
- **Abort:**
  - `abort` = 1 in RUN or DRAIN returns the state to IDLE on the next edge.
  - `sum_i` goes to 0, with no `done` and no `result` update.
  - The accumulator keeps any partial sum.
  - `abort` in IDLE or DONE has no effect.
  - `abort` together with `start` in IDLE means no run is started.
- **Arithmetic:** none is performed in the sequencer datapath. Accumulator wrap-around (mod 2^WIDTH) is a property of `sum8` and is passed through unchanged.

## Timing
- Start is sampled at edge E0.
  - RUN occupies cycles E0+1 .. E0+len.
  - DRAIN occupies the next ACC_LAT cycles.
  - `done` is high in cycle E0+len+ACC_LAT+1.
- `result` is valid in the same cycle `done` is high, and stays stable afterwards.
- `busy` rises in cycle E0+1 and falls after the DONE cycle.
- Back-to-back runs: the minimum start-to-start spacing is len+ACC_LAT+2 cycles.
- Asynchronous reset during a run clears everything immediately. `sum_i` = 0 while `rst` is low.

## Configuration
- **`SUM8_SEQ_CHECK_EN` defined:** compiles in a self-check.
  - On an accepted `start`, capture `base` = `sum_o`.
  - A shadow register accumulates `base` + Σ`mem[0..len-1]` mod 2^WIDTH.
  - At the DRAIN→DONE edge, `mismatch` <= (`sum_o` != shadow).
  - `mismatch` is sticky until reset, and is marked debug for the ILA.
- **Undefined:** the `mismatch` port and all checker logic are absent. All other behaviour is identical.

## Test plan
- **Nominal run:** load 3,5,7,2,4,6 into slots 0..5, accumulator at 0, `cfg_len`=6, pulse `start`.
  - `sum_i` shows 3,5,7,2,4,6 in cycles 1..6.
  - `done` is high in cycle 8 with ACC_LAT=1.
  - `result` = 27.
  - `mismatch` = 0.
- **Wrap:** slots 200,100, `len`=2, base 0.
  - `result` = 44.
  - No `mismatch`.
- **Zero length:** `cfg_len`=0 with accumulator at 27.
  - `done` is high in cycle 2.
  - `result` = 27.
  - `sum_i` stays 0 throughout.
- **Ignored inputs:** `start` and `cfg_we` pulsed mid-run.
  - No restart.
  - Memory is unchanged.
  - The `done` cycle is as in the nominal run.
- **Abort:** `abort` in RUN cycle 3 of the nominal run.
  - `busy` drops next cycle.
  - No `done`.
  - `result` is unchanged.
  - Accumulator = 15.
- **Reset and checker:** `rst` asserted mid-DRAIN clears all outputs to 0 asynchronously. With `SUM8_SEQ_CHECK_EN`, forcing `sum_o` to 0x00 in the nominal run sets `mismatch` = 1, and it remains set.
